expr_prec_engine: RTL
=====================

# expr_prec_engine

Streaming operator-precedence expression compiler in hardware. It consumes a token stream and emits register-machine instructions into the code-generation pipeline. Registers are allocated stack-wise: a value's register index equals its value-stack depth at push, so call arguments and other operands land in consecutive registers. It is the parametrised successor of the software precedence loop. It adds configurable operator/value depth, per-token associativity, parentheses, prefix operators, backpressure and error recovery.

## Interface
- `OPW`, 32: immediate operand width.
- `OPCW`, 5: opcode width.
- `PRECW`, 3: precedence width. Prefix operators use precedence 2^PRECW-1.
- `DEPTH`, 8: operator-stack entries, power of 2.
- `NREG`, 16: value-stack depth and register count, power of 2.

Ports:
- `clk`  in  1: the single clock.
- `rst`  in  1: asynchronous, active-high reset.
- `tok_valid`  in  1: token present.
- `tok_ready`  out  1: token accepted when `tok_valid & tok_ready`.
- `tok_kind`  in  3: 0 OPERAND, 1 INFIX, 2 PREFIX, 3 LPAREN, 4 RPAREN, 5 END.
- `tok_op`  in  OPCW: operator opcode.
- `tok_prec`  in  PRECW: infix precedence; 0 is invalid.
- `tok_rassoc`  in  1: infix operator is right-associative.
- `tok_imm`  in  OPW: operand value.
- `ins_valid`  out  1: instruction present.
- `ins_ready`  in  1: downstream accepts.
- `ins_kind`  out  2: 0 LOADI, 1 BINOP, 2 UNOP.
- `ins_op`  out  OPCW: opcode.
- `ins_rd`  out  log2(NREG): destination register, also lhs.
- `ins_rs`  out  log2(NREG): rhs register. Equals rd for UNOP; 0 for LOADI.
- `ins_imm`  out  OPW: LOADI value, else 0.
- `done`  out  1: one-cycle pulse at the end of an expression; the result is in R0.
- `err`  out  1: one-cycle pulse.
- `err_code`  out  3: 1 SYNTAX, 2 PAREN, 3 OPSTK_OVF, 4 REG_OVF. Valid with `err`.

## Operation
- States: IDLE, REDUCE, EMIT, FLUSH, DRAIN.
- The `expect_operand` flag is set at reset, after END, after INFIX, after PREFIX and after LPAREN.
- IDLE (`tok_ready`=1) latches one token.
  - OPERAND with `expect_operand`: emit LOADI rd=vdepth, imm; vdepth++.
  - OPERAND otherwise: SYNTAX. vdepth==NREG: REG_OVF.
  - PREFIX or LPAREN with `expect_operand`: push onto the operator stack. Otherwise SYNTAX. A full stack gives OPSTK_OVF.
  - INFIX without `expect_operand`: enter REDUCE with the held token. Otherwise SYNTAX.
  - RPAREN without `expect_operand`: enter FLUSH until LPAREN. Otherwise SYNTAX.
  - END without `expect_operand`: enter FLUSH to empty. Otherwise SYNTAX.
- REDUCE pops one operator per emitted instruction while the top is not LPAREN and (top.prec > held.prec, or top.prec == held.prec and !held.rassoc). Then it pushes the held operator and returns to IDLE.
- Reducing a binary operator emits BINOP rd=vdepth-2, rs=vdepth-1, then vdepth--.
- Reducing a prefix operator emits UNOP rd=rs=vdepth-1; vdepth is unchanged.
- FLUSH for RPAREN pops and reduces until LPAREN. The LPAREN is popped silently. Reaching an empty stack gives PAREN.
- FLUSH for END reduces all entries. Any LPAREN found gives PAREN. Then `done` pulses and both stacks clear. A correct expression leaves vdepth==1.
- Error: `err` pulses for one cycle and the block enters DRAIN. DRAIN accepts and discards tokens through END, then clears both stacks and returns to IDLE. No `done` pulse follows.
- `ins_*` holds stable while `ins_valid & !ins_ready`. `tok_ready`=0 whenever an instruction is pending.

## Timing
- Reset values:
  - `tok_ready`=0 while `rst`=1, and 1 in the first cycle after deassertion.
  - `ins_valid`, `ins_kind`, `ins_op`, `ins_rd`, `ins_rs`, `ins_imm`, `done`, `err`, `err_code` all reset to 0.
  - The stacks are empty and `expect_operand`=1.
- Throughput: at most one token accepted per cycle and at most one instruction per cycle.
- Latency: an OPERAND accepted in cycle N gives LOADI valid in cycle N+1.
- A reduction chain of k operators takes k instruction handshakes. After the last handshake, `tok_ready` returns in the next cycle.
- `done` and `err` are registered. `done` asserts in the cycle after the final reduction handshake, or in the cycle after END if there are no pending operators.
- Mid-operation reset: everything discards immediately and asynchronously. Any pending instruction is lost.

## Test plan
- `2 + 3 * 4 END` with prec(+)=1, prec(*)=2 -> LOADI R0,2; LOADI R1,3; LOADI R2,4; BINOP mul R1,R2; BINOP add R0,R1; then `done`.
- `8 - 3 - 1 END` left-associative -> BINOP sub R0,R1 is emitted before LOADI R1,1, then BINOP sub R0,R1; max vdepth 2.
- `1 ^ 2 ^ 3 END` with `tok_rassoc`=1 -> LOADI R0..R2; BINOP R1,R2; BINOP R0,R1.
- `- ( 1 + 2 ) END` -> LOADI R0,1; LOADI R1,2; BINOP add R0,R1; UNOP neg R0,R0; `done`.
- Errors:
  - `1 2 END` -> `err` with SYNTAX on the second operand; no `done`; the next clean expression starts again at R0.
  - `1 ) END` -> PAREN.
  - 9 nested LPAREN with DEPTH=8 -> OPSTK_OVF.
  - 17 chained right-associative operands with NREG=16 -> REG_OVF.
- Backpressure: hold `ins_ready`=0 for 5 cycles mid-chain -> `ins_*` stay stable, `tok_ready`=0, and no instruction is lost or duplicated.

Source files
------------

// File: rtl/expr_prec_if.sv
// Token-in / instruction-out bus of the operator-precedence expression engine.
interface expr_prec_if #(
    parameter int unsigned OPW   = 32,
    parameter int unsigned OPCW  = 5,
    parameter int unsigned PRECW = 3,
    parameter int unsigned NREG  = 16
);
    localparam int unsigned RW = $clog2(NREG);

    logic             tok_valid;
    logic             tok_ready;
    logic [2:0]       tok_kind;
    logic [OPCW-1:0]  tok_op;
    logic [PRECW-1:0] tok_prec;
    logic             tok_rassoc;
    logic [OPW-1:0]   tok_imm;

    logic             ins_valid;
    logic             ins_ready;
    logic [1:0]       ins_kind;
    logic [OPCW-1:0]  ins_op;
    logic [RW-1:0]    ins_rd;
    logic [RW-1:0]    ins_rs;
    logic [OPW-1:0]   ins_imm;

    logic             done;
    logic             err;
    logic [2:0]       err_code;

    modport master (
        output tok_valid, tok_kind, tok_op, tok_prec, tok_rassoc, tok_imm, ins_ready,
        input  tok_ready, ins_valid, ins_kind, ins_op, ins_rd, ins_rs, ins_imm,
               done, err, err_code
    );

    modport slave (
        input  tok_valid, tok_kind, tok_op, tok_prec, tok_rassoc, tok_imm, ins_ready,
        output tok_ready, ins_valid, ins_kind, ins_op, ins_rd, ins_rs, ins_imm,
               done, err, err_code
    );
endinterface

// File: rtl/expr_prec_engine.sv
// Streaming operator-precedence compiler: tokens in, stack-allocated register
// machine instructions out, with parentheses, prefix operators and error drain.
module expr_prec_engine #(
    parameter int unsigned OPW   = 32,
    parameter int unsigned OPCW  = 5,
    parameter int unsigned PRECW = 3,
    parameter int unsigned DEPTH = 8,
    parameter int unsigned NREG  = 16
) (
    input  logic       clk,
    input  logic       rst,
    expr_prec_if.slave bus
);
    localparam int unsigned RW = $clog2(NREG);
    localparam int unsigned SW = $clog2(DEPTH);
    localparam int unsigned VW = RW + 1;
    localparam int unsigned PW = SW + 1;

    localparam logic [PRECW-1:0] PREFIX_PREC = '1;

    localparam logic [2:0] K_OPERAND = 3'd0;
    localparam logic [2:0] K_INFIX   = 3'd1;
    localparam logic [2:0] K_PREFIX  = 3'd2;
    localparam logic [2:0] K_LPAREN  = 3'd3;
    localparam logic [2:0] K_RPAREN  = 3'd4;
    localparam logic [2:0] K_END     = 3'd5;

    localparam logic [1:0] I_LOADI = 2'd0;
    localparam logic [1:0] I_BINOP = 2'd1;
    localparam logic [1:0] I_UNOP  = 2'd2;

    localparam logic [2:0] E_SYNTAX = 3'd1;
    localparam logic [2:0] E_PAREN  = 3'd2;
    localparam logic [2:0] E_OPSTK  = 3'd3;
    localparam logic [2:0] E_REG    = 3'd4;

    localparam logic [1:0] N_BIN  = 2'd0;
    localparam logic [1:0] N_PRE  = 2'd1;
    localparam logic [1:0] N_LPAR = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REDUCE = 3'd1,
        S_EMIT   = 3'd2,
        S_FLUSH  = 3'd3,
        S_DRAIN  = 3'd4
    } state_e;

    typedef struct packed {
        logic [1:0]       kind;
        logic [OPCW-1:0]  op;
        logic [PRECW-1:0] prec;
    } ent_t;

    state_e           state_q, state_d;
    logic             expect_q, expect_d;
    logic [VW-1:0]    vdepth_q, vdepth_d;
    logic [PW-1:0]    sp_q, sp_d;
    ent_t             stk_q [DEPTH];
    ent_t             stk_d [DEPTH];
    logic [OPCW-1:0]  held_op_q, held_op_d;
    logic [PRECW-1:0] held_prec_q, held_prec_d;
    logic             held_rassoc_q, held_rassoc_d;
    logic             flush_end_q, flush_end_d;
    logic             ins_valid_q, ins_valid_d;
    logic [1:0]       ins_kind_q, ins_kind_d;
    logic [OPCW-1:0]  ins_op_q, ins_op_d;
    logic [RW-1:0]    ins_rd_q, ins_rd_d;
    logic [RW-1:0]    ins_rs_q, ins_rs_d;
    logic [OPW-1:0]   ins_imm_q, ins_imm_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;

    logic             tok_ready_c;
    logic             tok_fire;
    logic             slot_free;
    logic             reduce_go;
    logic             pop_emit;
    logic             raise_err;
    logic             err_at_end;
    logic             do_clear;
    logic [2:0]       err_sel;
    ent_t             top;

    // Tokens are taken only when no instruction is waiting on the output.
    assign tok_ready_c = ~rst & ((state_q == S_IDLE) | (state_q == S_DRAIN)) & ~ins_valid_q;

    always_comb begin
        state_d       = state_q;
        expect_d      = expect_q;
        vdepth_d      = vdepth_q;
        sp_d          = sp_q;
        stk_d         = stk_q;
        held_op_d     = held_op_q;
        held_prec_d   = held_prec_q;
        held_rassoc_d = held_rassoc_q;
        flush_end_d   = flush_end_q;
        ins_valid_d   = ins_valid_q & ~bus.ins_ready;
        ins_kind_d    = ins_kind_q;
        ins_op_d      = ins_op_q;
        ins_rd_d      = ins_rd_q;
        ins_rs_d      = ins_rs_q;
        ins_imm_d     = ins_imm_q;
        done_d        = 1'b0;
        err_d         = 1'b0;
        err_code_d    = 3'd0;
        pop_emit      = 1'b0;
        raise_err     = 1'b0;
        err_at_end    = 1'b0;
        do_clear      = 1'b0;
        err_sel       = 3'd0;

        tok_fire  = bus.tok_valid & tok_ready_c;
        slot_free = ~ins_valid_q | bus.ins_ready;
        top       = stk_q[SW'(sp_q - PW'(1))];
        reduce_go = (sp_q != '0) && (top.kind != N_LPAR) &&
                    ((top.prec > held_prec_q) ||
                     ((top.prec == held_prec_q) && !held_rassoc_q));

        case (state_q)
            S_IDLE: begin
                if (tok_fire) begin
                    case (bus.tok_kind)
                        K_OPERAND: begin
                            if (!expect_q) begin
                                raise_err = 1'b1;
                                err_sel   = E_SYNTAX;
                            end else if (vdepth_q == VW'(NREG)) begin
                                raise_err = 1'b1;
                                err_sel   = E_REG;
                            end else begin
                                ins_valid_d = 1'b1;
                                ins_kind_d  = I_LOADI;
                                ins_op_d    = '0;
                                ins_rd_d    = RW'(vdepth_q);
                                ins_rs_d    = '0;
                                ins_imm_d   = bus.tok_imm;
                                vdepth_d    = vdepth_q + VW'(1);
                                expect_d    = 1'b0;
                                state_d     = S_EMIT;
                            end
                        end
                        K_PREFIX, K_LPAREN: begin
                            if (!expect_q) begin
                                raise_err = 1'b1;
                                err_sel   = E_SYNTAX;
                            end else if (sp_q == PW'(DEPTH)) begin
                                raise_err = 1'b1;
                                err_sel   = E_OPSTK;
                            end else begin
                                if (bus.tok_kind == K_PREFIX)
                                    stk_d[SW'(sp_q)] = {N_PRE, bus.tok_op, PREFIX_PREC};
                                else
                                    stk_d[SW'(sp_q)] = {N_LPAR, bus.tok_op, PRECW'(0)};
                                sp_d = sp_q + PW'(1);
                            end
                        end
                        K_INFIX: begin
                            if (expect_q || (bus.tok_prec == '0)) begin
                                raise_err = 1'b1;
                                err_sel   = E_SYNTAX;
                            end else begin
                                held_op_d     = bus.tok_op;
                                held_prec_d   = bus.tok_prec;
                                held_rassoc_d = bus.tok_rassoc;
                                expect_d      = 1'b1;
                                state_d       = S_REDUCE;
                            end
                        end
                        K_RPAREN: begin
                            if (expect_q) begin
                                raise_err = 1'b1;
                                err_sel   = E_SYNTAX;
                            end else if (sp_q == '0) begin
                                raise_err = 1'b1;
                                err_sel   = E_PAREN;
                            end else begin
                                flush_end_d = 1'b0;
                                state_d     = S_FLUSH;
                            end
                        end
                        K_END: begin
                            // The END token is consumed here, so its errors skip DRAIN.
                            if (expect_q) begin
                                raise_err  = 1'b1;
                                err_at_end = 1'b1;
                                err_sel    = E_SYNTAX;
                            end else if (sp_q == '0) begin
                                done_d   = 1'b1;
                                do_clear = 1'b1;
                            end else begin
                                flush_end_d = 1'b1;
                                state_d     = S_FLUSH;
                            end
                        end
                        default: begin
                            raise_err = 1'b1;
                            err_sel   = E_SYNTAX;
                        end
                    endcase
                end
            end
            S_EMIT: begin
                if (bus.ins_ready) state_d = S_IDLE;
            end
            S_REDUCE: begin
                if (slot_free) begin
                    if (reduce_go) begin
                        pop_emit = 1'b1;
                    end else if (sp_q == PW'(DEPTH)) begin
                        raise_err = 1'b1;
                        err_sel   = E_OPSTK;
                    end else begin
                        stk_d[SW'(sp_q)] = {N_BIN, held_op_q, held_prec_q};
                        sp_d    = sp_q + PW'(1);
                        state_d = S_IDLE;
                    end
                end
            end
            S_FLUSH: begin
                if (slot_free) begin
                    if (sp_q == '0) begin
                        if (flush_end_q) begin
                            done_d   = 1'b1;
                            do_clear = 1'b1;
                        end else begin
                            raise_err = 1'b1;
                            err_sel   = E_PAREN;
                        end
                    end else if (top.kind == N_LPAR) begin
                        if (flush_end_q) begin
                            raise_err  = 1'b1;
                            err_at_end = 1'b1;
                            err_sel    = E_PAREN;
                        end else begin
                            sp_d    = sp_q - PW'(1);
                            state_d = S_IDLE;
                        end
                    end else begin
                        pop_emit = 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (tok_fire && (bus.tok_kind == K_END)) do_clear = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // Reduce the top operator into one instruction on the value stack.
        if (pop_emit) begin
            ins_valid_d = 1'b1;
            ins_op_d    = top.op;
            ins_imm_d   = '0;
            sp_d        = sp_q - PW'(1);
            if (top.kind == N_PRE) begin
                ins_kind_d = I_UNOP;
                ins_rd_d   = RW'(vdepth_q - VW'(1));
                ins_rs_d   = RW'(vdepth_q - VW'(1));
            end else begin
                ins_kind_d = I_BINOP;
                ins_rd_d   = RW'(vdepth_q - VW'(2));
                ins_rs_d   = RW'(vdepth_q - VW'(1));
                vdepth_d   = vdepth_q - VW'(1);
            end
        end

        if (raise_err) begin
            err_d      = 1'b1;
            err_code_d = err_sel;
            if (err_at_end) do_clear = 1'b1;
            else            state_d  = S_DRAIN;
        end

        if (do_clear) begin
            sp_d     = '0;
            vdepth_d = '0;
            expect_d = 1'b1;
            state_d  = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            expect_q      <= 1'b1;
            vdepth_q      <= '0;
            sp_q          <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) stk_q[i] <= '0;
            held_op_q     <= '0;
            held_prec_q   <= '0;
            held_rassoc_q <= 1'b0;
            flush_end_q   <= 1'b0;
            ins_valid_q   <= 1'b0;
            ins_kind_q    <= '0;
            ins_op_q      <= '0;
            ins_rd_q      <= '0;
            ins_rs_q      <= '0;
            ins_imm_q     <= '0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
            err_code_q    <= '0;
        end else begin
            state_q       <= state_d;
            expect_q      <= expect_d;
            vdepth_q      <= vdepth_d;
            sp_q          <= sp_d;
            stk_q         <= stk_d;
            held_op_q     <= held_op_d;
            held_prec_q   <= held_prec_d;
            held_rassoc_q <= held_rassoc_d;
            flush_end_q   <= flush_end_d;
            ins_valid_q   <= ins_valid_d;
            ins_kind_q    <= ins_kind_d;
            ins_op_q      <= ins_op_d;
            ins_rd_q      <= ins_rd_d;
            ins_rs_q      <= ins_rs_d;
            ins_imm_q     <= ins_imm_d;
            done_q        <= done_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
        end
    end

    assign bus.tok_ready = tok_ready_c;
    assign bus.ins_valid = ins_valid_q;
    assign bus.ins_kind  = ins_kind_q;
    assign bus.ins_op    = ins_op_q;
    assign bus.ins_rd    = ins_rd_q;
    assign bus.ins_rs    = ins_rs_q;
    assign bus.ins_imm   = ins_imm_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.err_code  = err_code_q;
endmodule
